// File: rtl/handshake_mulf_pipe_pkg.sv
// Shared constants for the elastic fixed-point multiplier and its join logic.
// Defaults describe a Q3.28 datapath with a four-deep pipe.
package handshake_mulf_pipe_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned FRAC_BITS_DEF  = 28;
  localparam int unsigned LATENCY_DEF    = 4;
  localparam int unsigned LATENCY_MIN    = 1;
  localparam int unsigned LATENCY_MAX    = 8;

  function automatic bit latency_legal(input int unsigned lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/handshake_mulf_pipe_join2.sv
// Two-input handshake join: a token passes only when both inputs are present.
// Each ready looks at the other side's valid so no loop forms through a producer.
module handshake_join2 (
  input  logic in0_valid,
  input  logic in1_valid,
  input  logic out_ready,
  output logic in0_ready,
  output logic in1_ready,
  output logic fire
);

  // Join handshake: both sides are consumed together or not at all.
  always_comb begin
    in0_ready = out_ready && in1_valid;
    in1_ready = out_ready && in0_valid;
    fire      = in0_valid && in1_valid && out_ready;
  end

endmodule

// File: rtl/handshake_mulf_pipe.sv
// Elastic signed fixed-point multiplier: joins lhs/rhs, emits (lhs*rhs)>>>FRAC_BITS
// after LATENCY cycles; a stall at the output freezes every stage.
module handshake_mulf_pipe
  import handshake_mulf_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned LATENCY    = LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic                  lhs_valid,
  output logic                  lhs_ready,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic                  rhs_valid,
  output logic                  rhs_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  // An illegal LATENCY yields index -1 below and fails elaboration.
  localparam int LAST = latency_legal(LATENCY) ? int'(LATENCY) - 1 : -1;

  logic                  en_s;
  logic                  fire_s;
  logic [DATA_WIDTH-1:0] product_s;

  function automatic logic [DATA_WIDTH-1:0] mulf(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return DATA_WIDTH'((PROD_W'($signed(a)) * PROD_W'($signed(b))) >>> FRAC_BITS);
  endfunction

  assign en_s = !result_valid || result_ready;

  handshake_join2 u_join (
    .in0_valid (lhs_valid),
    .in1_valid (rhs_valid),
    .out_ready (en_s),
    .in0_ready (lhs_ready),
    .in1_ready (rhs_ready),
    .fire      (fire_s)
  );

  // Full-width product, scaled and truncated before entering stage 0.
  always_comb begin
    product_s = mulf(lhs, rhs);
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic                  v_in_s;
    logic [DATA_WIDTH-1:0] d_in_s;
    logic                  v_r;
    logic [DATA_WIDTH-1:0] d_r;

    if (k == 0) begin : g_head
      assign v_in_s = fire_s;
      assign d_in_s = product_s;
    end else begin : g_tail
      assign v_in_s = g_stage[k-1].v_r;
      assign d_in_s = g_stage[k-1].d_r;
    end

    // Stage register: valid clears on reset, data is left unreset and moves with the pipe.
    always_ff @(posedge clk) begin
      if (!rst) begin
        v_r <= 1'b0;
      end else if (en_s) begin
        v_r <= v_in_s;
      end
      if (en_s) begin
        d_r <= d_in_s;
      end
    end
  end

  assign result_valid = g_stage[LAST].v_r;
  assign result       = g_stage[LAST].d_r;

endmodule

// File: tb/tb_handshake_mulf_pipe.sv
// Directed bench for handshake_mulf_pipe: stimulus pushes hand-computed results into a
// scoreboard queue; a forked monitor pops and compares on every output transfer.
module tb_handshake_mulf_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lhs;
  logic        lhs_valid;
  logic        lhs_ready;
  logic [31:0] rhs;
  logic        rhs_valid;
  logic        rhs_ready;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] sb[$];
  int          pop_log[$];

  // Backpressure stream: 1*0.5, 2*1.5, -1*0.25, 0.5*0.5, 7*7 (wraps), lsb*-lsb (floors)
  logic [31:0] bp_a[6] = '{32'h1000_0000, 32'h2000_0000, 32'hF000_0000,
                           32'h0800_0000, 32'h7000_0000, 32'h0000_0001};
  logic [31:0] bp_b[6] = '{32'h0800_0000, 32'h1800_0000, 32'h0400_0000,
                           32'h0800_0000, 32'h7000_0000, 32'hFFFF_FFFF};
  logic [31:0] bp_e[6] = '{32'h0800_0000, 32'h3000_0000, 32'hFC00_0000,
                           32'h0400_0000, 32'h1000_0000, 32'hFFFF_FFFF};

  handshake_mulf_pipe #(
    .DATA_WIDTH (32),
    .FRAC_BITS  (28),
    .LATENCY    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lhs          (lhs),
    .lhs_valid    (lhs_valid),
    .lhs_ready    (lhs_ready),
    .rhs          (rhs),
    .rhs_valid    (rhs_valid),
    .rhs_ready    (rhs_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic        hold_p;
    logic [31:0] held;
    logic [31:0] e;
    hold_p = 1'b0;
    held   = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_p = 1'b0;
      end else begin
        if (hold_p) begin
          chk("hold_valid", {31'd0, result_valid}, 32'd1);
          chk("hold_data", result, held);
        end
        hold_p = result_valid && !result_ready;
        held   = result;
        if (result_valid && result_ready) begin
          pop_log.push_back(cyc);
          chk("token_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("result", result, e);
          end
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                      output int fc);
    int w;
    w  = 0;
    fc = -1;
    lhs = a;
    rhs = b;
    lhs_valid = 1'b1;
    rhs_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (lhs_ready && rhs_ready) begin
        sb.push_back(e);
        fc = cyc;
        break;
      end
      w++;
      if (w > 100) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got=ready_low want=accept (cycle %0d)", cyc);
        break;
      end
    end
    step();
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      step();
      w++;
    end
    repeat (6) step();
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  // Checks result_valid over five cycles after a lone fire: high only on the fourth.
  task automatic latency_window(input string tag);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk(tag, {31'd0, result_valid}, {31'd0, (k == 4)});
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fc;
    int f0;
    int gaps;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;

    rst = 1'b0;
    lhs = 32'd0;
    rhs = 32'd0;
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
    result_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) step();
    @(negedge clk);
    chk("reset_valid", {31'd0, result_valid}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Basic product and exact latency.
    send(32'h1000_0000, 32'h0800_0000, 32'h0800_0000, fc);
    latency_window("latency_basic");
    drain("basic");

    // Signs and truncation toward -inf.
    send(32'hF000_0000, 32'h0800_0000, 32'hF800_0000, fc);
    send(32'hF000_0000, 32'hF000_0000, 32'h1000_0000, fc);
    send(32'h0000_0001, 32'h0000_0001, 32'h0000_0000, fc);
    send(32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, fc);
    drain("sign");

    // Join: lhs alone is never consumed.
    pop_log.delete();
    lhs = 32'h2000_0000;
    rhs = 32'h0400_0000;
    lhs_valid = 1'b1;
    rhs_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("join_lhs_ready_alone", {31'd0, lhs_ready}, 32'd0);
      chk("join_rhs_ready_alone", {31'd0, rhs_ready}, 32'd1);
      step();
    end
    rhs_valid = 1'b1;
    @(negedge clk);
    chk("join_lhs_ready_both", {31'd0, lhs_ready}, 32'd1);
    chk("join_rhs_ready_both", {31'd0, rhs_ready}, 32'd1);
    sb.push_back(32'h0800_0000);
    step();
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
    drain("join");
    chk("join_token_count", 32'(pop_log.size()), 32'd1);

    // Backpressure mid-stream.
    pop_log.delete();
    fork
      begin : bp_src
        int fcd;
        for (int i = 0; i < 6; i++) send(bp_a[i], bp_b[i], bp_e[i], fcd);
      end
      begin : bp_sink
        repeat (4) step();
        result_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_lhs_ready", {31'd0, lhs_ready}, 32'd0);
          chk("stall_rhs_ready", {31'd0, rhs_ready}, 32'd0);
          chk("stall_result_valid", {31'd0, result_valid}, 32'd1);
          step();
        end
        result_ready = 1'b1;
      end
    join
    drain("backpressure");
    chk("backpressure_count", 32'(pop_log.size()), 32'd6);

    // Full throughput: 20 back-to-back tokens.
    pop_log.delete();
    f0 = -1;
    for (int i = 0; i < 20; i++) begin
      b = 32'(i) * 32'h0010_0000;
      if (i % 2 == 0) begin
        a = 32'h1000_0000;
        e = b;
      end else begin
        a = 32'hE000_0000;
        e = 32'd0 - (b << 1);
      end
      send(a, b, e, fc);
      if (i == 0) f0 = fc;
    end
    drain("throughput");
    chk("throughput_count", 32'(pop_log.size()), 32'd20);
    if (pop_log.size() == 20) begin
      chk("throughput_first_latency", 32'(pop_log[0] - f0), 32'd4);
      gaps = 0;
      for (int i = 1; i < 20; i++) begin
        if (pop_log[i] - pop_log[i-1] != 1) gaps++;
      end
      chk("throughput_gaps", 32'(gaps), 32'd0);
    end

    // Reset with three tokens in flight.
    pop_log.delete();
    send(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, fc);
    send(32'h2000_0000, 32'h1000_0000, 32'h2000_0000, fc);
    send(32'h3000_0000, 32'h1000_0000, 32'h3000_0000, fc);
    rst = 1'b0;
    step();
    rst = 1'b1;
    sb.delete();
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_quiet", {31'd0, result_valid}, 32'd0);
    end
    step();
    send(32'h1800_0000, 32'h1800_0000, 32'h2400_0000, fc);
    latency_window("latency_after_reset");
    drain("reset");
    chk("post_reset_token_count", 32'(pop_log.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
